// File: rtl/rf_param_if.sv
// Register-file port bundle: two read ports, one write port, bulk-clear control and a debug tap.
// The master drives addresses, write data and control; the slave returns read data and status.
interface rf_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DBG_W  = 16
) ();

    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              clr_req;
    logic              busy;
    logic [ADDR_W-1:0] dbg_index;
    logic [DBG_W-1:0]  dbg_data;

    modport master (
        output rs,
        output rt,
        output we,
        output waddr,
        output wdata,
        output clr_req,
        output dbg_index,
        input  rs_data,
        input  rt_data,
        input  busy,
        input  dbg_data
    );

    modport slave (
        input  rs,
        input  rt,
        input  we,
        input  waddr,
        input  wdata,
        input  clr_req,
        input  dbg_index,
        output rs_data,
        output rt_data,
        output busy,
        output dbg_data
    );

endinterface

// File: rtl/rf_param.sv
// Parametrised single-write, dual-read register file with registered reads, write-to-read
// bypass, optional hard-wired-zero entry 0, a bulk-clear sequencer and a combinational debug tap.
module rf_param #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter bit          ZERO_R0 = 1'b1,
    parameter int unsigned DBG_W   = 16
) (
    input logic      clk,
    input logic      rst_n,
    rf_param_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_d;

    logic              w_clearing;
    logic              w_wr_commit;
    logic [DATA_W-1:0] w_rs_data_d;
    logic [DATA_W-1:0] w_rt_data_d;
    logic [DATA_W-1:0] w_dbg_entry;

    assign w_clearing  = (r_state == StClear);
    // Writes only land while idle; a write to entry 0 is dropped when it is hard-wired to zero.
    assign w_wr_commit = bus.we && !w_clearing && !(ZERO_R0 && (bus.waddr == '0));

    // Next read value for one port: zero entry, then same-edge bypass, then the entry being
    // cleared at this edge, then the stored contents.
    function automatic logic [DATA_W-1:0] read_next(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (ZERO_R0 && (addr == '0)) begin
            val = '0;
        end else if (w_wr_commit && (bus.waddr == addr)) begin
            val = bus.wdata;
        end else if (w_clearing && (r_ptr == addr)) begin
            val = '0;
        end else begin
            val = r_mem[addr];
        end
        return val;
    endfunction

    // Clear-sequencer next state and pointer.
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        unique case (r_state)
            StIdle: begin
                if (bus.clr_req) begin
                    w_state_d = StClear;
                    w_ptr_d   = '0;
                end
            end
            StClear: begin
                // Pointer wraps to 0 on the edge that clears the last entry.
                w_ptr_d = r_ptr + 1'b1;
                if (r_ptr == {ADDR_W{1'b1}}) begin
                    w_state_d = StIdle;
                end
            end
        endcase
    end

    // Clear-sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
        end
    end

    // Storage array: one write per edge, or one cleared entry per edge while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clearing) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_commit) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
    end

    // Read-port next values.
    always_comb begin
        w_rs_data_d = read_next(bus.rs);
        w_rt_data_d = read_next(bus.rt);
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
        end else begin
            r_rs_data <= w_rs_data_d;
            r_rt_data <= w_rt_data_d;
        end
    end

    // Debug tap: raw array view, no bypass.
    always_comb begin
        w_dbg_entry = r_mem[bus.dbg_index];
        if (ZERO_R0 && (bus.dbg_index == '0)) begin
            w_dbg_entry = '0;
        end
    end

    assign bus.rs_data  = r_rs_data;
    assign bus.rt_data  = r_rt_data;
    assign bus.busy     = w_clearing;
    assign bus.dbg_data = w_dbg_entry[DBG_W-1:0];

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: one instance with a hard-wired zero entry, one without,
// sharing the same stimulus. Expected values go into a scoreboard queue when driven and
// are popped when the corresponding output is sampled.
module tb_rf_param;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        clr_req;
    logic [4:0]  dbg_index;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    rf_param_if #(.DATA_W(32), .ADDR_W(5), .DBG_W(16)) if0 ();
    rf_param_if #(.DATA_W(32), .ADDR_W(5), .DBG_W(16)) if1 ();

    assign if0.rs = rs;
    assign if0.rt = rt;
    assign if0.we = we;
    assign if0.waddr = waddr;
    assign if0.wdata = wdata;
    assign if0.clr_req = clr_req;
    assign if0.dbg_index = dbg_index;
    assign if1.rs = rs;
    assign if1.rt = rt;
    assign if1.we = we;
    assign if1.waddr = waddr;
    assign if1.wdata = wdata;
    assign if1.clr_req = clr_req;
    assign if1.dbg_index = dbg_index;

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1'b1), .DBG_W(16)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if0.slave)
    );

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1'b0), .DBG_W(16)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // OR of every entry seen through both debug taps.
    task automatic dbg_or(output logic [31:0] acc);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            dbg_index = i[4:0];
            #1;
            acc = acc | {16'h0, if0.dbg_data} | {16'h0, if1.dbg_data};
        end
    endtask

    // OR of every entry seen through both read ports of both instances.
    task automatic read_or(output logic [31:0] acc);
        acc = '0;
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs = i[4:0];
            rt = 5'(31 - i);
            tick();
            acc = acc | if0.rs_data | if0.rt_data | if1.rs_data | if1.rt_data;
        end
    endtask

    // Bounded wait for the clear to finish; a timeout shows up as a busy mismatch.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (if0.busy === 1'b0) break;
            tick();
        end
        sb_push(32'd0);
        sb_check(tag, {31'd0, if0.busy});
    endtask

    initial begin
        logic [31:0] acc;
        int busy_cnt;

        rst_n = 1'b0;
        rs = '0;
        rt = '0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        clr_req = 1'b0;
        dbg_index = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state.
        sb_push(32'd0);
        sb_check("rst_rs_data", if0.rs_data);
        sb_push(32'd0);
        sb_check("rst_busy", {31'd0, if0.busy});

        // Write with same-edge bypass, then normal read on the other port.
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        rs = 5'd5;
        rt = 5'd0;
        sb_push(32'hDEADBEEF);
        sb_push(32'd0);
        tick();
        sb_check("bypass_rs", if0.rs_data);
        sb_check("rt_r0", if0.rt_data);
        we = 1'b0;
        rt = 5'd5;
        sb_push(32'hDEADBEEF);
        tick();
        sb_check("read_rt", if0.rt_data);
        dbg_index = 5'd5;
        sb_push(32'h0000BEEF);
        #1;
        sb_check("dbg_5", {16'h0, if0.dbg_data});

        // Write to entry 0: dropped with the zero entry, stored without it.
        we = 1'b1;
        waddr = 5'd0;
        wdata = 32'h12345678;
        rs = 5'd0;
        sb_push(32'd0);
        sb_push(32'h12345678);
        tick();
        sb_check("r0_same_edge", if0.rs_data);
        sb_check("nz_r0_bypass", if1.rs_data);
        we = 1'b0;
        sb_push(32'd0);
        sb_push(32'h12345678);
        tick();
        sb_check("r0_after", if0.rs_data);
        sb_check("nz_r0_after", if1.rs_data);
        dbg_index = 5'd0;
        sb_push(32'd0);
        sb_push(32'h00005678);
        #1;
        sb_check("r0_dbg", {16'h0, if0.dbg_data});
        sb_check("nz_r0_dbg", {16'h0, if1.dbg_data});

        // Fill entries 1..31 with their index.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1;
            waddr = i[4:0];
            wdata = 32'(i);
            tick();
        end
        we = 1'b0;
        rs = 5'd17;
        rt = 5'd31;
        sb_push(32'd17);
        sb_push(32'd31);
        tick();
        sb_check("fill_rs17", if0.rs_data);
        sb_check("fill_rt31", if0.rt_data);

        // Bulk clear: count busy cycles, read mid-clear, write and re-request while busy.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (if0.busy !== 1'b1) break;
            busy_cnt++;
            if (i == 0) begin
                rs = 5'd20;
                sb_push(32'd20);
            end
            if (i == 1) sb_check("read_during_clear", if0.rs_data);
            if (i == 5) begin
                we = 1'b1;
                waddr = 5'd7;
                wdata = 32'hFFFFFFFF;
            end
            if (i == 6) we = 1'b0;
            if (i == 10) clr_req = 1'b1;
            if (i == 11) clr_req = 1'b0;
            tick();
        end
        sb_push(32'd32);
        sb_check("busy_cycles", 32'(busy_cnt));
        dbg_or(acc);
        sb_push(32'd0);
        sb_check("clear_dbg_all_zero", acc);
        read_or(acc);
        sb_push(32'd0);
        sb_check("clear_read_all_zero", acc);

        // Write colliding with clear start commits, then is wiped when the pointer reaches it.
        we = 1'b1;
        waddr = 5'd3;
        wdata = 32'hA5A5A5A5;
        clr_req = 1'b1;
        dbg_index = 5'd3;
        tick();
        we = 1'b0;
        clr_req = 1'b0;
        sb_push(32'h0000A5A5);
        sb_check("coll_e0", {16'h0, if0.dbg_data});
        tick();
        tick();
        sb_push(32'h0000A5A5);
        sb_check("coll_e2", {16'h0, if0.dbg_data});
        tick();
        tick();
        sb_push(32'd0);
        sb_check("coll_e4", {16'h0, if0.dbg_data});
        wait_idle("coll_idle");

        // Reset in the middle of a clear.
        we = 1'b1;
        waddr = 5'd25;
        wdata = 32'h25;
        tick();
        we = 1'b0;
        rs = 5'd25;
        rt = 5'd25;
        dbg_index = 5'd25;
        sb_push(32'h25);
        tick();
        sb_check("pre_rst_rs", if0.rs_data);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        #3;
        rst_n = 1'b0;
        #1;
        sb_push(32'd0);
        sb_check("midrst_busy", {31'd0, if0.busy});
        sb_push(32'd0);
        sb_check("midrst_rs", if0.rs_data);
        sb_push(32'd0);
        sb_check("midrst_rt", if1.rt_data);
        sb_push(32'd0);
        sb_check("midrst_dbg", {16'h0, if1.dbg_data});
        tick();
        rst_n = 1'b1;
        dbg_or(acc);
        sb_push(32'd0);
        sb_check("postrst_dbg_all_zero", acc);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        sb_push(32'd1);
        sb_check("clr_after_reset", {31'd0, if0.busy});
        wait_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
